// File: rtl/xor_descrambler.sv
// rtl/xor_descrambler.sv - sync-word hunter and x^7+x^6+1 keystream descrambler
module xor_descrambler #(
    parameter logic [15:0] SYNC_WORD    = 16'hA5C3,
    parameter int unsigned PAYLOAD_BITS = 64,
    parameter logic [6:0]  SEED         = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    output logic       dout,
    output logic       dout_valid,
    output logic       locked,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    // An all-zero seed locks the LFSR at zero; frame length must fit the 16-bit counter.
    if (SEED == 7'h00) begin : g_bad_seed
        $error("xor_descrambler: SEED must be nonzero");
    end
    if (PAYLOAD_BITS < 1 || PAYLOAD_BITS > 65535) begin : g_bad_len
        $error("xor_descrambler: PAYLOAD_BITS must be 1..65535");
    end

    localparam logic [15:0] LAST_BIT = 16'(PAYLOAD_BITS - 1);

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    // Only the 15 most recent bits are kept; the 16th comes straight from din.
    logic [14:0] sr_q, sr_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [15:0] bitcnt_q, bitcnt_d;
    logic        dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] window;

    assign window = {sr_q, din};

    // Next-state logic: hunt for sync in clear, then descramble a fixed-length payload.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        lfsr_d       = lfsr_q;
        bitcnt_d     = bitcnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    sr_d = window[14:0];
                    if (window == SYNC_WORD) begin
                        state_d  = ST_PAYLOAD;
                        lfsr_d   = SEED;
                        bitcnt_d = 16'd0;
                    end
                end
                ST_PAYLOAD: begin
                    dout_d       = din ^ lfsr_q[6];
                    dout_valid_d = 1'b1;
                    lfsr_d       = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                    bitcnt_d     = bitcnt_q + 16'd1;
                    if (bitcnt_q == LAST_BIT) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        state_d      = ST_HUNT;
                        // Clearing history keeps payload bits out of the next sync match.
                        sr_d         = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // State and output registers with asynchronous frame abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            sr_q         <= '0;
            lfsr_q       <= SEED;
            bitcnt_q     <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            lfsr_q       <= lfsr_d;
            bitcnt_q     <= bitcnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign locked     = (state_q == ST_PAYLOAD);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_xor_descrambler.sv
// tb/tb_xor_descrambler.sv - directed-vector bench for xor_descrambler
module tb_xor_descrambler;

    localparam logic [31:0] SYNC = 32'h0000_A5C3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;

    logic       dout9, dv9, lock9, fd9_o;
    logic [7:0] fcnt9;
    logic       dout32, dv32, lock32, fd32_o;
    logic [7:0] fcnt32;

    xor_descrambler #(.PAYLOAD_BITS(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .dout(dout9), .dout_valid(dv9), .locked(lock9),
        .frame_done(fd9_o), .frame_cnt(fcnt9)
    );

    xor_descrambler #(.PAYLOAD_BITS(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .dout(dout32), .dout_valid(dv32), .locked(lock32),
        .frame_done(fd32_o), .frame_cnt(fcnt32)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Running monitor counters, sampled on the falling edge.
    int          sv9 = 0, fd9 = 0, lk9 = 0, cc9 = 0, badf9 = 0;
    int          sv32 = 0, fd32 = 0, lk32 = 0;
    logic [31:0] sh9 = '0, sh32 = '0;
    logic        prev9 = 1'b0;
    logic [8:0]  exp9 = 9'h1FC;

    int b_sv9, b_fd9, b_lk9, b_cc9, b_badf9, b_sv32, b_fd32, b_lk32;

    always @(negedge clk) begin
        if (dv9) begin
            sv9 <= sv9 + 1;
            sh9 <= {sh9[30:0], dout9};
        end
        if (fd9_o) begin
            fd9 <= fd9 + 1;
            if ({sh9[7:0], dout9} !== exp9) badf9 <= badf9 + 1;
        end
        if (lock9) lk9 <= lk9 + 1;
        if (dv9 && prev9) cc9 <= cc9 + 1;
        prev9 <= dv9;
        if (dv32) begin
            sv32 <= sv32 + 1;
            sh32 <= {sh32[30:0], dout32};
        end
        if (fd32_o) fd32 <= fd32 + 1;
        if (lock32) lk32 <= lk32 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_sv9 = sv9; b_fd9 = fd9; b_lk9 = lk9; b_cc9 = cc9; b_badf9 = badf9;
        b_sv32 = sv32; b_fd32 = fd32; b_lk32 = lk32;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            din       = v[i];
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            if (gap) begin
                din_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        din       = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n     = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        #2;
        do_reset();
        check_eq("reset_outs9", 32'({dout9, dv9, lock9, fd9_o}), 32'h0);
        check_eq("reset_cnt9", 32'(fcnt9), 32'h0);
        check_eq("reset_outs32", 32'({dout32, dv32, lock32, fd32_o}), 32'h0);

        // Keystream-matching payload descrambles to all zeros.
        snap();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'h1FC, 9, 1'b0);
        idle(2);
        check_eq("t1_strobes", 32'(sv9 - b_sv9), 32'd9);
        check_eq("t1_bits", 32'(sh9[8:0]), 32'h0);
        check_eq("t1_locked_cycles", 32'(lk9 - b_lk9), 32'd9);
        check_eq("t1_frame_done", 32'(fd9 - b_fd9), 32'd1);
        check_eq("t1_frame_cnt", 32'(fcnt9), 32'd1);

        // All-zero payload exposes the keystream itself.
        snap();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'h000, 9, 1'b0);
        idle(2);
        check_eq("t2_strobes", 32'(sv9 - b_sv9), 32'd9);
        check_eq("t2_bits", 32'(sh9[8:0]), 32'h1FC);
        check_eq("t2_frame_cnt", 32'(fcnt9), 32'd2);

        // Preamble plus gapped stream must decode exactly like the gapless one.
        do_reset();
        snap();
        send_bits(32'h00FF, 16, 1'b1);
        send_bits(SYNC, 16, 1'b1);
        send_bits(32'h166, 9, 1'b1);
        idle(2);
        check_eq("t3_strobes", 32'(sv9 - b_sv9), 32'd9);
        check_eq("t3_bits", 32'(sh9[8:0]), 32'h09A);
        check_eq("t3_locked_cycles", 32'(lk9 - b_lk9), 32'd18);
        check_eq("t3_consecutive_dv", 32'(cc9 - b_cc9), 32'd0);
        check_eq("t3_frame_cnt", 32'(fcnt9), 32'd1);
        snap();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'h166, 9, 1'b0);
        idle(2);
        check_eq("t3_gapless_bits", 32'(sh9[8:0]), 32'h09A);
        check_eq("t3_gapless_locked", 32'(lk9 - b_lk9), 32'd9);

        // Sync pattern embedded in a 32-bit payload must not re-lock.
        do_reset();
        snap();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'hA5C3_A5C3, 32, 1'b0);
        idle(3);
        check_eq("t4_strobes", 32'(sv32 - b_sv32), 32'd32);
        check_eq("t4_bits", sh32, 32'h5BC7_BD92);
        check_eq("t4_frame_done", 32'(fd32 - b_fd32), 32'd1);
        check_eq("t4_locked_cycles", 32'(lk32 - b_lk32), 32'd32);
        check_eq("t4_unlocked_after", 32'(lock32), 32'd0);
        check_eq("t4_frame_cnt", 32'(fcnt32), 32'd1);

        // Asynchronous mid-frame reset.
        do_reset();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'h00, 5, 1'b0);
        check_eq("t5_pre_state", 32'({dout9, dv9, lock9}), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_outs", 32'({dout9, dv9, lock9, fd9_o}), 32'h0);
        check_eq("t5_async_cnt", 32'(fcnt9), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        snap();
        send_bits(SYNC, 16, 1'b0);
        send_bits(32'h000, 9, 1'b0);
        idle(2);
        check_eq("t5_after_bits", 32'(sh9[8:0]), 32'h1FC);
        check_eq("t5_after_cnt", 32'(fcnt9), 32'd1);
        check_eq("t5_after_done", 32'(fd9 - b_fd9), 32'd1);

        // 256 back-to-back frames wrap the frame counter.
        do_reset();
        exp9 = 9'h1FC;
        snap();
        for (int f = 0; f < 256; f++) begin
            send_bits(SYNC, 16, 1'b0);
            send_bits(32'h000, 9, 1'b0);
            if (f == 254) check_eq("t6_cnt_255", 32'(fcnt9), 32'd255);
        end
        idle(2);
        check_eq("t6_cnt_wrap", 32'(fcnt9), 32'd0);
        check_eq("t6_frame_done", 32'(fd9 - b_fd9), 32'd256);
        check_eq("t6_strobes", 32'(sv9 - b_sv9), 32'd2304);
        check_eq("t6_locked_cycles", 32'(lk9 - b_lk9), 32'd2304);
        check_eq("t6_bad_frames", 32'(badf9 - b_badf9), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
